operand_register: RTL and testbench
===================================

Name: operand_register

Overview:
- Single-port, word-addressed operand store that holds one matrix operand as MATRIX_SIZE words of DATA_WIDTH bits.
- Sits between the host/load path and the matrix datapath.
- The loader writes elements one word per cycle. The datapath or host reads any element back by address.
- One shared address port serves both write and read.

Parameters:
- DATA_WIDTH, 32, width of each stored element in bits.
- ADDR_WIDTH, 4, width of the element address.
- MATRIX_SIZE, 16, number of stored elements. Must satisfy 1 <= MATRIX_SIZE <= 2**ADDR_WIDTH.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-high reset. Despite the name suffix, reset is asserted when rst_ni = 1.
- write_data_Mat_i  input  DATA_WIDTH  data to store at addr_Mat_i.
- addr_Mat_i  input  ADDR_WIDTH  element address for both write and read.
- write_en_Mat_i  input  1  1 = write write_data_Mat_i to addr_Mat_i on this rising edge; 0 = read only.
- read_data_Mat_o  output  DATA_WIDTH  contents of the element at addr_Mat_i.

Behaviour:
- Storage: array mem[0..MATRIX_SIZE-1], each entry DATA_WIDTH bits.
- Reset:
  - While rst_ni = 1, all entries are forced to 0 immediately, without waiting for a clock edge.
  - While reset is held, write_en_Mat_i is ignored.
  - read_data_Mat_o = 0 throughout reset.
- Write:
  - Occurs on a rising edge of clk_i with rst_ni = 0, write_en_Mat_i = 1 and addr_Mat_i < MATRIX_SIZE.
  - Effect: mem[addr_Mat_i] <= write_data_Mat_i.
  - Exactly one entry changes per cycle; all other entries hold.
- Read:
  - Combinational, zero latency: read_data_Mat_o = mem[addr_Mat_i] whenever addr_Mat_i < MATRIX_SIZE.
  - Read is independent of write_en_Mat_i. The output tracks address changes within the same cycle.
- Read-during-write, same address:
  - Before the edge, the output shows the old value.
  - After the edge, it shows the new value in the same cycle.
  - No internal bypass is required.
- Out-of-range address (addr_Mat_i >= MATRIX_SIZE, only possible when MATRIX_SIZE < 2**ADDR_WIDTH):
  - Writes are silently dropped.
  - read_data_Mat_o = 0.
  - No wrap-around or aliasing.
- Reset mid-operation:
  - Asserting rst_ni at any time, including during a write cycle, clears every entry.
  - A write coincident with reset is lost.
- Holding write_en_Mat_i = 1 with a constant address and data across many cycles rewrites the same value; this is harmless.
- No X propagation from uninitialised storage: every entry is defined after the first reset.
- No handshake, no stall, no ready/valid signalling.

Decomposition:
- Shared package (operand_pkg): default DATA_WIDTH, ADDR_WIDTH, MATRIX_SIZE constants, and an element data type for reuse by the matrix datapath.
- No sub-module: a single flat module containing the storage array, write decode and read mux.

Test Plan:
1. Reset and clear:
   - Stimulus: hold rst_ni = 1 for 10 ns with write_en = 1, addr = 0, data = 0, then release.
   - Required: read_data_Mat_o = 0 for every address 0..15.
2. Write then read, address 0:
   - Stimulus: addr = 0, data = 8, write_en = 1 for one edge; then write_en = 0.
   - Required: read_data_Mat_o = 8 from the cycle after the edge and held on subsequent cycles.
3. Write then read, address 2:
   - Stimulus: addr = 2, data = 88, write_en = 1; then write_en = 0.
   - Required: read = 88 at address 2. Switching addr to 0 returns 8 combinationally; address 1 returns 0.
4. Full fill:
   - Stimulus: write 0x1000 + i to every address i = 0..15.
   - Required: read back each address and get the matching value. Overwrite address 15 with 0xFFFFFFFF and confirm only address 15 changes.
5. Asynchronous reset mid-sequence:
   - Stimulus: after test 4, pulse rst_ni = 1 between clock edges while write_en = 1.
   - Required: output goes to 0 immediately without a clock edge; all entries read 0 afterwards and the coincident write is lost.
6. Out-of-range address (MATRIX_SIZE = 12 variant):
   - Stimulus: write 0xDEAD to address 13.
   - Required: read_data_Mat_o = 0 at address 13, and addresses 0..11 are unchanged.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared sizing constants and element type for the matrix operand store and
// the datapath that consumes it.
package operand_pkg;

  localparam int OP_DATA_WIDTH  = 32;
  localparam int OP_ADDR_WIDTH  = 4;
  localparam int OP_MATRIX_SIZE = 16;

  typedef logic [OP_DATA_WIDTH-1:0] operand_elem_t;

endpackage : operand_pkg

// File: rtl/operand_register.sv
// Single-port, word-addressed operand store: synchronous write, combinational
// read, asynchronous clear. Out-of-range addresses neither write nor alias.
module operand_register
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH  = OP_DATA_WIDTH,
  parameter int ADDR_WIDTH  = OP_ADDR_WIDTH,
  parameter int MATRIX_SIZE = OP_MATRIX_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] write_data_Mat_i,
  input  logic [ADDR_WIDTH-1:0] addr_Mat_i,
  input  logic                  write_en_Mat_i,
  output logic [DATA_WIDTH-1:0] read_data_Mat_o
);

  // One extra bit so MATRIX_SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH + 1)'(MATRIX_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [MATRIX_SIZE];
  logic                  w_addr_valid;
  logic [DATA_WIDTH-1:0] w_read_data;

  // Address range decode shared by the write enable and the read mux.
  always_comb begin
    w_addr_valid = 1'b0;
    if ({1'b0, addr_Mat_i} < LP_SIZE) begin
      w_addr_valid = 1'b1;
    end else begin
      w_addr_valid = 1'b0;
    end
  end

  // Storage: cleared while reset is high, otherwise one entry written per edge.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write_en_Mat_i && w_addr_valid) begin
      r_mem[addr_Mat_i] <= write_data_Mat_i;
    end
  end

  // Read mux; reset and out-of-range addresses return zero.
  always_comb begin
    w_read_data = '0;
    if (rst_ni) begin
      w_read_data = '0;
    end else if (w_addr_valid) begin
      w_read_data = r_mem[addr_Mat_i];
    end else begin
      w_read_data = '0;
    end
  end

  assign read_data_Mat_o = w_read_data;

endmodule : operand_register

// File: tb/tb_operand_register.sv
// Scoreboard bench for operand_register: a 16-entry and a 12-entry instance
// share one stimulus stream; a monitor compares queued expectations.
module tb_operand_register;

  logic        clk;
  logic        rst;
  logic [31:0] wdata;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] rd16;
  logic [31:0] rd12;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q  [$];
  bit          sel_q  [$];
  string       name_q [$];
  event        sample_ev;

  operand_register #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MATRIX_SIZE(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst),
    .write_data_Mat_i (wdata),
    .addr_Mat_i       (addr),
    .write_en_Mat_i   (we),
    .read_data_Mat_o  (rd16)
  );

  operand_register #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MATRIX_SIZE(12)) dut12 (
    .clk_i            (clk),
    .rst_ni           (rst),
    .write_data_Mat_i (wdata),
    .addr_Mat_i       (addr),
    .write_en_Mat_i   (we),
    .read_data_Mat_o  (rd12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drains the scoreboard each time stimulus flags a sample point.
  initial begin
    logic [31:0] e;
    logic [31:0] act;
    bit          s;
    string       n;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        s   = sel_q.pop_front();
        n   = name_q.pop_front();
        act = s ? rd12 : rd16;
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", n, act, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic expect_rd(input string nm, input bit sel, input logic [31:0] e);
    #1;
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(nm);
    ->sample_ev;
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  initial begin
    logic [31:0] v;

    // 1: reset with a write attempt pending
    rst   = 1'b1;
    we    = 1'b1;
    addr  = 4'd0;
    wdata = 32'd0;
    expect_rd("rst_out", 1'b0, 32'h0000_0000);
    #8;
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      expect_rd($sformatf("rst_clear[%0d]", i), 1'b0, 32'h0000_0000);
    end

    // 2: address 0, including read-during-write ordering
    @(negedge clk);
    addr  = 4'd0;
    wdata = 32'd8;
    we    = 1'b1;
    expect_rd("rdw_old_a0", 1'b0, 32'h0000_0000);
    @(posedge clk);
    expect_rd("rdw_new_a0", 1'b0, 32'h0000_0008);
    @(negedge clk);
    we = 1'b0;
    repeat (2) @(negedge clk);
    expect_rd("hold_a0", 1'b0, 32'h0000_0008);

    // 3: address 2 and combinational address switching
    wr(4'd2, 32'd88);
    addr = 4'd2;
    expect_rd("rd_a2", 1'b0, 32'd88);
    addr = 4'd0;
    expect_rd("rd_a0_again", 1'b0, 32'd8);
    addr = 4'd1;
    expect_rd("rd_a1_empty", 1'b0, 32'd0);

    // 4: full fill then a single overwrite
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 32'h0000_1000 + 32'(i));
    end
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      expect_rd($sformatf("fill[%0d]", i), 1'b0, 32'h0000_1000 + 32'(i));
    end
    wr(4'd15, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      v    = (i == 15) ? 32'hFFFF_FFFF : 32'h0000_1000 + 32'(i);
      expect_rd($sformatf("ovw[%0d]", i), 1'b0, v);
    end

    // 5: asynchronous reset pulse between edges with a write pending
    @(negedge clk);
    addr  = 4'd15;
    wdata = 32'h0000_1234;
    we    = 1'b1;
    #1;
    rst = 1'b1;
    expect_rd("async_rst_out", 1'b0, 32'h0000_0000);
    rst = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      expect_rd($sformatf("post_rst[%0d]", i), 1'b0, 32'h0000_0000);
    end

    // 6: out-of-range write on the 12-entry instance
    for (int i = 0; i < 12; i++) begin
      wr(4'(i), 32'h0000_0200 + 32'(i));
    end
    wr(4'd13, 32'h0000_DEAD);
    addr = 4'd13;
    expect_rd("oor_rd13_12", 1'b1, 32'h0000_0000);
    expect_rd("inr_rd13_16", 1'b0, 32'h0000_DEAD);
    for (int i = 0; i < 12; i++) begin
      addr = 4'(i);
      expect_rd($sformatf("oor_keep[%0d]", i), 1'b1, 32'h0000_0200 + 32'(i));
    end
    for (int i = 12; i < 16; i++) begin
      addr = 4'(i);
      expect_rd($sformatf("oor_zero[%0d]", i), 1'b1, 32'h0000_0000);
    end

    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_operand_register
